// File: rtl/fetch_unit_prefetch.sv
// rtl/fetch_unit_prefetch.sv - MIPS instruction-fetch stage with a prefetch queue feeding the IF/ID register
module fetch_unit_prefetch #(
    parameter int                  PC_WIDTH    = 10,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             branch_taken,
    input  logic [PC_WIDTH-1:0]              branch_target,
    input  logic                             jump_taken,
    input  logic [PC_WIDTH-1:0]              jump_target,
    input  logic                             id_ready,
    output logic                             imem_req,
    output logic [PC_WIDTH-1:0]              imem_addr,
    input  logic [INSTR_WIDTH-1:0]           imem_rdata,
    output logic                             id_valid,
    output logic [INSTR_WIDTH-1:0]           id_instr,
    output logic [PC_WIDTH-1:0]              id_pc_next,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH+1);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = 1;
    localparam logic [PTR_W-1:0]    PTR_ONE = 1;
    localparam logic [CNT_W:0]      DEPTH_C = (CNT_W+1)'(QUEUE_DEPTH);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]    inflight_addr_q, inflight_addr_d;
    logic                   id_valid_q, id_valid_d;
    logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;
    logic [PC_WIDTH-1:0]    id_pc_next_q, id_pc_next_d;
    logic [INSTR_WIDTH-1:0] q_instr_q [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] q_instr_d [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]    q_tag_q [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]    q_tag_d [QUEUE_DEPTH];

    logic                redirect, issue, load_en, push, pop;
    logic [PC_WIDTH-1:0] target, ret_tag;

    // Branch wins over jump: it belongs to the older instruction.
    assign redirect = branch_taken | jump_taken;
    assign target   = branch_taken ? branch_target : jump_target;
    // One queue slot is reserved for every read still in flight, so pushes never overflow.
    assign issue    = !reset && !redirect
                      && (({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C);
    assign load_en  = !id_valid_q || id_ready;
    assign ret_tag  = inflight_addr_q + PC_ONE;

    always_comb begin
        pc_d            = pc_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        id_valid_d      = id_valid_q;
        id_instr_d      = id_instr_q;
        id_pc_next_d    = id_pc_next_q;
        q_instr_d       = q_instr_q;
        q_tag_d         = q_tag_q;
        push            = 1'b0;
        pop             = 1'b0;
        if (redirect) begin
            pc_d       = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            id_valid_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d            = pc_q + PC_ONE;
                inflight_d      = 1'b1;
                inflight_addr_d = pc_q;
            end
            push = inflight_q;
            if (load_en) begin
                if (count_q != '0) begin
                    id_instr_d   = q_instr_q[rd_ptr_q];
                    id_pc_next_d = q_tag_q[rd_ptr_q];
                    id_valid_d   = 1'b1;
                    rd_ptr_d     = rd_ptr_q + PTR_ONE;
                    pop          = 1'b1;
                end else if (inflight_q) begin
                    // Empty queue: returning word bypasses straight into IF/ID.
                    id_instr_d   = imem_rdata;
                    id_pc_next_d = ret_tag;
                    id_valid_d   = 1'b1;
                    push         = 1'b0;
                end else begin
                    id_valid_d = 1'b0;
                end
            end
            if (push) begin
                q_instr_d[wr_ptr_q] = imem_rdata;
                q_tag_d[wr_ptr_q]   = ret_tag;
                wr_ptr_d            = wr_ptr_q + PTR_ONE;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            id_valid_q      <= 1'b0;
            id_instr_q      <= '0;
            id_pc_next_q    <= '0;
        end else begin
            pc_q            <= pc_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            id_valid_q      <= id_valid_d;
            id_instr_q      <= id_instr_d;
            id_pc_next_q    <= id_pc_next_d;
        end
    end

    always_ff @(posedge clk) begin
        q_instr_q <= q_instr_d;
        q_tag_q   <= q_tag_d;
    end

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_next  = id_pc_next_q;
    assign queue_count = count_q;
endmodule
